fir_channel_sequencer: RTL and testbench
========================================

# fir_channel_sequencer

Sequences the shared band-pass FIR filter across all beamformer channels. On `start`, for each channel in turn it resets the filter, streams that channel's samples from the input RAM into the filter's Avalon-ST sink, and writes every filtered result into the output RAM at the matching address. It sits between the capture RAMs and `BP_Filt` and is the only block that drives the filter. When it finishes it raises `done` for one cycle; an error flag reports any fault seen during the run.

## Interface
- `N_CH`, 4, channel count (power of two)
- `CH_W`, 2, log2(N_CH)
- `SAMP_W`, 11, log2(samples per channel); each channel holds 2^SAMP_W samples
- `DIN_W`, 12, sample width
- `DOUT_W`, 93, filter output width
- `RD_LAT`, 2, input RAM read latency in cycles (registered q)
- `TIMEOUT`, 1023, maximum DRAIN cycles without a `fir_src_valid`
- Clocking and reset (already decided): one clock `clk`; reset `rst` is synchronous and active-low.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-low reset
- `start`  in  1  one-cycle pulse that begins a full run
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle pulse at the end of a run
- `err`  out  1  sticky fault flag; cleared by the next accepted `start`
- `in_addr`  out  CH_W+SAMP_W  input RAM address, {ch, sample}
- `in_rden`  out  1  input RAM read enable
- `in_q`  in  DIN_W  input RAM data
- `fir_rst_n`  out  1  filter reset_n
- `fir_sink_data`  out  DIN_W  filter sink data
- `fir_sink_valid`  out  1  filter sink valid
- `fir_sink_error`  out  2  filter sink error; always 2'b00
- `fir_src_data`  in  DOUT_W  filter source data
- `fir_src_valid`  in  1  filter source valid
- `fir_src_error`  in  2  filter source error
- `out_addr`  out  CH_W+SAMP_W  output RAM address, {ch, sample}
- `out_wren`  out  1  output RAM write enable
- `out_data`  out  DOUT_W  output RAM write data

## Operation
- **States:** IDLE, FLUSH, FEED, DRAIN, NEXT, FINISH.
- **IDLE:** an accepted `start` clears `err` and the channel, read and write counters, then moves to FLUSH. `start` is ignored in every other state.
- **FLUSH:** holds `fir_rst_n` low for 2 cycles, then moves to FEED. This clears the filter's tap history between channels.
- **FEED:** asserts `in_rden` every cycle and increments the read counter. After sample 2^SAMP_W−1 is issued, moves to DRAIN.
- **Sink alignment:** `fir_sink_valid` is `in_rden` delayed by RD_LAT cycles; `fir_sink_data` is `in_q` taken directly.
- **Output capture:** on each `fir_src_valid`, register `out_data` ← `fir_src_data`, `out_addr` ← {ch, wr_cnt}, and `out_wren` ← 1; then increment `wr_cnt`. This applies in FEED and DRAIN.
  - A `fir_src_valid` arriving after `wr_cnt` has reached 2^SAMP_W, or in any other state, is dropped and sets `err`.
- **DRAIN:** when 2^SAMP_W outputs have been written, moves to NEXT. If the timeout counter reaches TIMEOUT first, sets `err` and moves to NEXT. The timeout counter resets on every `fir_src_valid`.
- **NEXT:** if ch = N_CH−1, moves to FINISH; otherwise increments ch, clears the counters, and moves to FLUSH.
- **FINISH:** pulses `done` for one cycle and returns to IDLE.
- **Error flags:** any nonzero `fir_src_error` together with `fir_src_valid` sets `err`; that sample is still written.
- **Counter width:** counters are SAMP_W+1 bits so the terminal count 2^SAMP_W is representable. Addresses use the low SAMP_W bits.

## Timing
- **Reset values:** `busy`=0, `done`=0, `err`=0, `in_rden`=0, `in_addr`=0, `fir_rst_n`=0 for the reset cycle then 1 in IDLE, `fir_sink_valid`=0, `out_wren`=0, `out_addr`=0, `out_data`=0. FSM state is IDLE.
- **Reset mid-run:** all state is abandoned and the FSM returns to IDLE, with no `done` pulse. The RAM pipelines are cleared.
- **Start to first read:** `start` at cycle t → FLUSH at t+1..t+2 → first `in_rden` at t+3. The first `fir_sink_valid` follows at t+3+RD_LAT.
- **Feed rate:** FEED lasts exactly 2^SAMP_W cycles, with `fir_sink_valid` continuous (no gaps).
- **Write latency:** `out_wren` is asserted exactly 1 cycle after the corresponding `fir_src_valid`.
- **Done pulse:** `done` and the falling edge of `busy` occur in the same cycle.

## Structure
- **Shared package `bf_pkg`:** FSM state enum `seq_state_t` and the `fir_err_t` encoding (2'b00 = ok).
- **Sub-module `rd_valid_pipe`:** a parameterised RD_LAT-stage shift register for the valid alignment, sharing the same `rst`.

## Test plan
- **Nominal run:** N_CH=2, SAMP_W=3, filter model with 5-cycle latency; RAM ch0 = 1..8, ch1 = 9..16. Expect 16 `out_wren` pulses at addresses 0..15, exactly one `done`, and `err`=0.
- **Channel flush:** check that `fir_rst_n` is low for exactly 2 cycles before each channel, and that no `fir_sink_valid` occurs during FLUSH.
- **Start while busy:** a second `start` pulse mid-FEED is ignored; the output count is still 16 and there is one `done`.
- **Timeout:** the filter model stops after 6 outputs on ch0. Expect `err`=1 after TIMEOUT idle cycles, ch1 still processed, and `done` asserted.
- **Source error:** `fir_src_error`=2'b01 on sample 3. Expect that sample written, `err` sticky at 1, and `err` cleared by the next `start`.
- **Reset mid-DRAIN:** `rst`=0 for one cycle. Expect all outputs at their reset values, IDLE, no `done`; a subsequent `start` completes normally.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared types for the beamformer FIR channel sequencer.
package bf_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_NEXT   = 3'd4,
    S_FINISH = 3'd5
  } seq_state_t;

  // Avalon-ST error field as carried on the filter sink/source.
  typedef logic [1:0] fir_err_t;
  localparam fir_err_t FIR_ERR_OK = 2'b00;

endpackage

// File: rtl/rd_valid_pipe.sv
// Delays the input RAM read enable so it lines up with the registered RAM data.
module rd_valid_pipe #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_valid
);

  logic [LAT-1:0] r_pipe;

  // Shift register, cleared by the same synchronous active-low reset as the sequencer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_valid;
      for (int i = 1; i < LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_valid = r_pipe[LAT-1];

endmodule

// File: rtl/fir_channel_sequencer.sv
// Runs the shared band-pass FIR over every channel: flush, feed, drain, store.
//
// state  | meaning
// IDLE   | waiting for start
// FLUSH  | filter held in reset for two cycles
// FEED   | one input RAM read per cycle for the current channel
// DRAIN  | waiting for the remaining filter outputs or the timeout
// NEXT   | advance to the next channel or finish
// FINISH | one-cycle done pulse
module fir_channel_sequencer
  import bf_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int SAMP_W  = 11,
  parameter int DIN_W   = 12,
  parameter int DOUT_W  = 93,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [CH_W+SAMP_W-1:0]   in_addr,
  output logic                     in_rden,
  input  logic [DIN_W-1:0]         in_q,
  output logic                     fir_rst_n,
  output logic [DIN_W-1:0]         fir_sink_data,
  output logic                     fir_sink_valid,
  output logic [1:0]               fir_sink_error,
  input  logic [DOUT_W-1:0]        fir_src_data,
  input  logic                     fir_src_valid,
  input  logic [1:0]               fir_src_error,
  output logic [CH_W+SAMP_W-1:0]   out_addr,
  output logic                     out_wren,
  output logic [DOUT_W-1:0]        out_data
);

  localparam int CNT_W = SAMP_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TERM    = {1'b1, {SAMP_W{1'b0}}};
  localparam logic [CNT_W-1:0] C_LAST_RD = {1'b0, {SAMP_W{1'b1}}};
  localparam logic [TO_W-1:0]  C_TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [CH_W-1:0]  C_CH_LAST = CH_W'(N_CH - 1);

  seq_state_t          r_state;
  logic [CH_W-1:0]     r_ch;
  logic [CNT_W-1:0]    r_rd_cnt;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic                r_flush_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_err;
  logic                r_out_wren;
  logic [CH_W+SAMP_W-1:0] r_out_addr;
  logic [DOUT_W-1:0]   r_out_data;

  logic w_start_ok;
  logic w_src_accept;
  logic w_src_drop;
  logic w_src_fault;
  logic w_wr_full;
  logic w_timeout;

  assign w_start_ok   = (r_state == S_IDLE) && start;
  assign w_wr_full    = (r_wr_cnt == C_TERM);
  // Results are only stored while a channel is live and not yet complete.
  assign w_src_accept = fir_src_valid && !w_wr_full &&
                        ((r_state == S_FEED) || (r_state == S_DRAIN));
  assign w_src_drop   = fir_src_valid && !w_src_accept;
  assign w_src_fault  = fir_src_valid && (fir_src_error != FIR_ERR_OK);
  assign w_timeout    = (r_state == S_DRAIN) && !w_wr_full && (r_to_cnt == C_TO_MAX);

  // Channel sequencing FSM with read and flush counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_rd_cnt    <= '0;
      r_flush_cnt <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ch        <= '0;
            r_rd_cnt    <= '0;
            r_flush_cnt <= 1'b0;
            r_state     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_flush_cnt <= ~r_flush_cnt;
          if (r_flush_cnt) r_state <= S_FEED;
        end
        S_FEED: begin
          r_rd_cnt <= r_rd_cnt + CNT_W'(1);
          if (r_rd_cnt == C_LAST_RD) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_wr_full || w_timeout) r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_ch == C_CH_LAST) begin
            r_state <= S_FINISH;
          end else begin
            r_ch        <= r_ch + CH_W'(1);
            r_rd_cnt    <= '0;
            r_flush_cnt <= 1'b0;
            r_state     <= S_FLUSH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Write counter: cleared per run and per channel, advanced on each stored result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_cnt <= '0;
    end else if (w_start_ok || (r_state == S_NEXT)) begin
      r_wr_cnt <= '0;
    end else if (w_src_accept) begin
      r_wr_cnt <= r_wr_cnt + CNT_W'(1);
    end
  end

  // Drain watchdog: counts DRAIN cycles since the last filter output, saturating.
  always_ff @(posedge clk) begin
    if (!rst || (r_state != S_DRAIN) || fir_src_valid) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != C_TO_MAX) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Sticky fault flag; a new fault in the start cycle takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_src_drop || w_src_fault || w_timeout) begin
      r_err <= 1'b1;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end
  end

  // Output RAM write port, one cycle behind the filter source.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_wren <= 1'b0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_out_wren <= w_src_accept;
      if (w_src_accept) begin
        r_out_addr <= {r_ch, r_wr_cnt[SAMP_W-1:0]};
        r_out_data <= fir_src_data;
      end
    end
  end

  rd_valid_pipe #(
    .LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_rden),
    .o_valid (fir_sink_valid)
  );

  assign busy           = (r_state != S_IDLE) && (r_state != S_FINISH);
  assign done           = (r_state == S_FINISH);
  assign err            = r_err;
  assign in_rden        = (r_state == S_FEED);
  assign in_addr        = {r_ch, r_rd_cnt[SAMP_W-1:0]};
  assign fir_rst_n      = rst && (r_state != S_FLUSH);
  assign fir_sink_data  = in_q;
  assign fir_sink_error = FIR_ERR_OK;
  assign out_wren       = r_out_wren;
  assign out_addr       = r_out_addr;
  assign out_data       = r_out_data;

endmodule

// File: tb/tb_fir_channel_sequencer.sv
// Directed bench: 2 channels x 8 samples, RAM and 5-cycle filter models.
module tb_fir_channel_sequencer;

  localparam int N_CH = 2, CH_W = 1, SAMP_W = 3, DIN_W = 12, DOUT_W = 93;
  localparam int RD_LAT = 2, TIMEOUT = 20, AW = CH_W + SAMP_W, NS = 16;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, err, in_rden, fir_rst_n, fir_sink_valid, fir_src_valid, out_wren;
  logic [AW-1:0] in_addr, out_addr;
  logic [DIN_W-1:0] in_q, fir_sink_data;
  logic [1:0] fir_sink_error, fir_src_error;
  logic [DOUT_W-1:0] fir_src_data, out_data;

  always #5 clk = ~clk;

  fir_channel_sequencer #(
    .N_CH(N_CH), .CH_W(CH_W), .SAMP_W(SAMP_W), .DIN_W(DIN_W),
    .DOUT_W(DOUT_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .in_addr(in_addr), .in_rden(in_rden), .in_q(in_q), .fir_rst_n(fir_rst_n),
    .fir_sink_data(fir_sink_data), .fir_sink_valid(fir_sink_valid),
    .fir_sink_error(fir_sink_error), .fir_src_data(fir_src_data),
    .fir_src_valid(fir_src_valid), .fir_src_error(fir_src_error),
    .out_addr(out_addr), .out_wren(out_wren), .out_data(out_data)
  );

  // Input RAM: sample value = address + 1, two-cycle registered read.
  logic [DIN_W-1:0] r_q1, r_q2;
  always @(posedge clk) begin
    r_q1 <= DIN_W'(in_addr) + DIN_W'(1);
    r_q2 <= r_q1;
  end
  assign in_q = r_q2;

  // Filter model: 5-cycle latency, output = 2*x + 7, pipeline cleared by reset_n.
  bit mode_stop, mode_err;
  logic [4:0] f_v;
  logic [4:0][DIN_W-1:0] f_d;
  int raw_idx;
  always @(posedge clk) begin
    if (!fir_rst_n) begin
      f_v <= '0;
    end else begin
      f_v <= {f_v[3:0], fir_sink_valid};
      f_d <= {f_d[3:0], fir_sink_data};
    end
    if (start && !busy) raw_idx <= 0;
    else if (f_v[4]) raw_idx <= raw_idx + 1;
  end
  assign fir_src_valid = f_v[4] && !(mode_stop && (raw_idx == 6 || raw_idx == 7));
  assign fir_src_data  = DOUT_W'(f_d[4]) * 2 + 7;
  assign fir_src_error = (mode_err && raw_idx == 3) ? 2'b01 : 2'b00;

  // Monitor
  bit mon_clr;
  int n_wr, n_done, bd_bad, sv_fl, fl_run;
  int hits [NS];
  logic [DOUT_W-1:0] got [NS];
  int fl_runs [$];
  logic prev_busy;
  always @(negedge clk) begin
    if (mon_clr) begin
      n_wr = 0; n_done = 0; bd_bad = 0; sv_fl = 0; fl_run = 0; prev_busy = 1'b0;
      fl_runs.delete();
      for (int a = 0; a < NS; a++) begin hits[a] = 0; got[a] = '0; end
    end else begin
      if (out_wren) begin n_wr++; hits[out_addr]++; got[out_addr] = out_data; end
      if (done) begin
        n_done++;
        if (busy || !prev_busy) bd_bad++;
      end
      if (!fir_rst_n) begin
        fl_run++;
        if (fir_sink_valid) sv_fl++;
      end else if (fl_run > 0) begin
        fl_runs.push_back(fl_run);
        fl_run = 0;
      end
      prev_busy = busy;
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check_eq("done_wait", 96'(0), 96'(1));
    tick();
  endtask

  task automatic wait_rden(input logic lvl);
    bit seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (in_rden === lvl) seen = 1'b1;
    end
    if (!seen) check_eq("rden_wait", 96'(0), 96'(1));
  endtask

  task automatic verify_run(input string nm, input int exp_wr, input bit to_mode, input bit exp_err);
    repeat (5) tick();
    check_eq({nm, "_writes"}, 96'(n_wr), 96'(exp_wr));
    for (int a = 0; a < NS; a++) begin
      if (to_mode && (a == 6 || a == 7)) begin
        check_eq($sformatf("%s_skip%0d", nm, a), 96'(hits[a]), 96'(0));
      end else begin
        check_eq($sformatf("%s_hit%0d", nm, a), 96'(hits[a]), 96'(1));
        check_eq($sformatf("%s_data%0d", nm, a), 96'(got[a]), 96'((a + 1) * 2 + 7));
      end
    end
    check_eq({nm, "_done_cnt"}, 96'(n_done), 96'(1));
    check_eq({nm, "_err"}, 96'(err), 96'(exp_err));
    check_eq({nm, "_busy_done"}, 96'(bd_bad), 96'(0));
    check_eq({nm, "_sv_in_flush"}, 96'(sv_fl), 96'(0));
    check_eq({nm, "_flush_cnt"}, 96'(fl_runs.size()), 96'(N_CH));
    foreach (fl_runs[i]) check_eq($sformatf("%s_flush_len%0d", nm, i), 96'(fl_runs[i]), 96'(2));
  endtask

  task automatic check_reset_vals(input string nm);
    check_eq({nm, "_busy"}, 96'(busy), 96'(0));
    check_eq({nm, "_done"}, 96'(done), 96'(0));
    check_eq({nm, "_err"}, 96'(err), 96'(0));
    check_eq({nm, "_in_rden"}, 96'(in_rden), 96'(0));
    check_eq({nm, "_in_addr"}, 96'(in_addr), 96'(0));
    check_eq({nm, "_fir_rst_n"}, 96'(fir_rst_n), 96'(0));
    check_eq({nm, "_sink_valid"}, 96'(fir_sink_valid), 96'(0));
    check_eq({nm, "_out_wren"}, 96'(out_wren), 96'(0));
    check_eq({nm, "_out_addr"}, 96'(out_addr), 96'(0));
    check_eq({nm, "_out_data"}, 96'(out_data), 96'(0));
  endtask

  initial begin
    int n_rd, n_sv;
    rst = 1'b0; start = 1'b0; mode_stop = 1'b0; mode_err = 1'b0; mon_clr = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    rst = 1'b1;
    tick();
    check_eq("idle_fir_rst_n", 96'(fir_rst_n), 96'(1));
    check_eq("sink_error", 96'(fir_sink_error), 96'(0));

    // Nominal run with start-to-read latency
    clear_mon();
    pulse_start();
    n_rd = 0; n_sv = 0;
    for (int n = 1; n <= 30 && n_sv == 0; n++) begin
      @(negedge clk);
      if (n == 1) check_eq("busy_after_start", 96'(busy), 96'(1));
      if (in_rden && n_rd == 0) n_rd = n;
      if (fir_sink_valid) n_sv = n;
    end
    check_eq("start_to_rden", 96'(n_rd), 96'(3));
    check_eq("start_to_sink_valid", 96'(n_sv), 96'(3 + RD_LAT));
    wait_done(300);
    verify_run("nom", 16, 1'b0, 1'b0);

    // Start while busy is ignored
    clear_mon();
    pulse_start();
    wait_rden(1'b1);
    tick(); tick();
    pulse_start();
    wait_done(300);
    verify_run("dbl", 16, 1'b0, 1'b0);

    // Timeout on ch0
    mode_stop = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(400);
    verify_run("tmo", 14, 1'b1, 1'b1);
    mode_stop = 1'b0;

    // Source error on sample 3, then cleared by the next start
    mode_err = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(300);
    verify_run("serr", 16, 1'b0, 1'b1);
    mode_err = 1'b0;
    clear_mon();
    pulse_start();
    @(negedge clk);
    check_eq("err_cleared", 96'(err), 96'(0));
    wait_done(300);
    verify_run("after_serr", 16, 1'b0, 1'b0);

    // Reset during ch0 DRAIN
    clear_mon();
    pulse_start();
    wait_rden(1'b1);
    wait_rden(1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check_reset_vals("midrst");
    rst = 1'b1;
    repeat (20) tick();
    check_eq("midrst_no_done", 96'(n_done), 96'(0));
    check_eq("midrst_idle_busy", 96'(busy), 96'(0));
    check_eq("midrst_idle_err", 96'(err), 96'(0));
    clear_mon();
    pulse_start();
    wait_done(300);
    verify_run("post_rst", 16, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
